// File: rtl/status_led_if.sv
// rtl/status_led_if.sv - status LED / LTSSM control signal bundle
interface status_led_if #(
  parameter int NUM_CH = 4
);
  logic [2*NUM_CH-1:0] mode_i;
  logic [NUM_CH-1:0]   act_i;
  logic                link_up_i;
  logic                retrain_req_i;
  logic [NUM_CH-1:0]   led_o;
  logic                heartbeat_o;
  logic                ltssm_enable_o;
  logic [7:0]          retrain_cnt_o;

  modport master (
    output mode_i, act_i, link_up_i, retrain_req_i,
    input  led_o, heartbeat_o, ltssm_enable_o, retrain_cnt_o
  );

  modport slave (
    input  mode_i, act_i, link_up_i, retrain_req_i,
    output led_o, heartbeat_o, ltssm_enable_o, retrain_cnt_o
  );
endinterface

// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - per-channel status LEDs, heartbeat and LTSSM enable sequencer
module status_led_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 24,
  parameter int STRETCH_W = 20,
  parameter int LTSSM_DLY = 1024,
  parameter int HOLD_CYC  = 256,
  parameter int LINK_TO   = 0
) (
  input  logic         core_clk,
  input  logic         core_rst_n,
  status_led_if.slave  bus
);

  localparam int MAX_A = (LTSSM_DLY > HOLD_CYC) ? LTSSM_DLY : HOLD_CYC;
  localparam int MAX_V = (LINK_TO > MAX_A) ? LINK_TO : MAX_A;
  localparam int CW    = (MAX_V < 2) ? 1 : $clog2(MAX_V);

  localparam logic [CW-1:0] DLY_LAST  = CW'(LTSSM_DLY - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LINK_LAST = CW'((LINK_TO == 0) ? 0 : LINK_TO - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_ENABLE, ST_HOLD} state_t;

  logic [CNT_W-1:0]     hb_cnt;
  logic [CNT_W-1:0]     hb_nxt;
  logic [STRETCH_W-1:0] stretch_cnt [NUM_CH];
  logic [NUM_CH-1:0]    led_q;
  logic [NUM_CH-1:0]    led_nxt;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 retrain_evt;
  logic                 en_q;
  logic [7:0]           rcnt_q;

  assign hb_nxt = hb_cnt + 1'b1;

  // LED is registered from next-cycle values so blink tracks hb_cnt exactly
  always_comb begin
    led_nxt = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      case (bus.mode_i[2*n +: 2])
        2'b00:   led_nxt[n] = 1'b0;
        2'b01:   led_nxt[n] = 1'b1;
        2'b10:   led_nxt[n] = hb_nxt[CNT_W-3];
        default: led_nxt[n] = bus.act_i[n] | (stretch_cnt[n] != '0);
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      hb_cnt <= '0;
      led_q  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        stretch_cnt[n] <= '0;
      end
    end else begin
      hb_cnt <= hb_nxt;
      led_q  <= led_nxt;
      for (int n = 0; n < NUM_CH; n++) begin
        if (bus.act_i[n]) begin
          stretch_cnt[n] <= '1;
        end else if (stretch_cnt[n] != '0) begin
          stretch_cnt[n] <= stretch_cnt[n] - 1'b1;
        end
      end
    end
  end

  // One counter serves the power-up delay, link-down watchdog and hold time
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retrain_evt = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ST_ENABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ENABLE: begin
        if (LINK_TO != 0) begin
          if (bus.link_up_i) begin
            cnt_d = '0;
          end else if (cnt_q == LINK_LAST) begin
            retrain_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (bus.retrain_req_i) begin
          retrain_evt = 1'b1;
        end
        if (retrain_evt) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_ENABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == ST_ENABLE);
      if (retrain_evt && (rcnt_q != 8'hFF)) begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  assign bus.led_o          = led_q;
  assign bus.heartbeat_o    = hb_cnt[CNT_W-1];
  assign bus.ltssm_enable_o = en_q;
  assign bus.retrain_cnt_o  = rcnt_q;

endmodule
